// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the Ex-stage multi-cycle divider.
package div_ctrl_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;
  localparam int CNT_W          = 6;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Magnitude of an operand; unsigned operands pass through untouched.
  function automatic logic [REG_BUS-1:0] abs_op(input logic [REG_BUS-1:0] v, input logic sgn);
    logic [REG_BUS-1:0] r;
    if (sgn && v[REG_BUS-1]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Ex <-> divider handshake: operands and start level in, result and ready out.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic                      signed_div_i;
  logic [REG_BUS-1:0]        opdata1_i;
  logic [REG_BUS-1:0]        opdata2_i;
  logic                      start_i;
  logic                      annul_i;
  logic [DOUBLE_REG_BUS-1:0] result_o;
  logic                      ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_ctrl.sv
// Restoring 32-bit divider, one quotient bit per cycle, with result {remainder, quotient}.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  div_bus
);

  div_state_e                state_q, state_d;
  logic [64:0]               work_q, work_d;
  logic [REG_BUS-1:0]        divisor_q, divisor_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      sign1_q, sign1_d;
  logic                      sign2_q, sign2_d;
  logic                      signed_q, signed_d;
  logic                      ready_q, ready_d;
  logic [DOUBLE_REG_BUS-1:0] result_q, result_d;

  logic [32:0]               diff;
  logic [64:0]               step;
  logic [REG_BUS-1:0]        quo_fix;
  logic [REG_BUS-1:0]        rem_fix;

  // Next-state, datapath step and output computation.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    signed_d  = signed_q;
    ready_d   = 1'b0;
    result_d  = 64'h0;

    // work_q[63:32] is the partial remainder with the next dividend bit shifted in.
    diff    = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    step    = diff[32] ? {work_q[63:0], 1'b0} : {diff[31:0], work_q[31:0], 1'b1};
    quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? (~step[31:0] + 32'd1) : step[31:0];
    rem_fix = (signed_q && sign1_q) ? (~step[64:33] + 32'd1) : step[64:33];

    case (state_q)
      DIV_FREE: begin
        if (div_bus.start_i && !div_bus.annul_i) begin
          if (div_bus.opdata2_i == 32'h0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d   = DIV_ON;
            work_d    = {32'h0, abs_op(div_bus.opdata1_i, div_bus.signed_div_i), 1'b0};
            divisor_d = abs_op(div_bus.opdata2_i, div_bus.signed_div_i);
            sign1_d   = div_bus.opdata1_i[31];
            sign2_d   = div_bus.opdata2_i[31];
            signed_d  = div_bus.signed_div_i;
            cnt_d     = 6'd0;
          end
        end else begin
          state_d = DIV_FREE;
        end
      end
      DIV_BY_ZERO: begin
        state_d = DIV_END;
        work_d  = 65'h0;
      end
      DIV_ON: begin
        if (div_bus.annul_i) begin
          state_d = DIV_FREE;
        end else if (cnt_q == 6'd31) begin
          state_d = DIV_END;
          work_d  = {rem_fix, step[32], quo_fix};
        end else begin
          work_d = step;
          cnt_d  = cnt_q + 6'd1;
        end
      end
      DIV_END: begin
        if (!div_bus.start_i || div_bus.annul_i) begin
          state_d = DIV_FREE;
        end else begin
          ready_d  = 1'b1;
          result_d = {work_q[64:33], work_q[31:0]};
        end
      end
      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      work_q    <= 65'h0;
      divisor_q <= 32'h0;
      cnt_q     <= 6'd0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      signed_q  <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= 64'h0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      signed_q  <= signed_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign div_bus.ready_o  = ready_q;
  assign div_bus.result_o = result_q;

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle 32-bit integer divider and its sequencing FSM for the Ex stage. Ex supplies operands, signedness and a start level, then holds its pipeline stall until the result is ready. Results cover DIV.W/DIV.WU (quotient) and MOD.W/MOD.WU (remainder). The block sits beside Ex; Ex's `stallreq_o` is driven while `start_i` is high and `ready_o` is low.

## Interface
Parameters:
- none; width is fixed by `RegBus` (32) and `DoubleRegBus` (64).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset (`RstEnable`)
- signed_div_i  in  1  1 = signed (DIV.W/MOD.W), 0 = unsigned
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  `DivStart`/`DivStop` level from Ex; held high until `ready_o`
- annul_i  in  1  cancel the in-flight operation (flush/exception)
- result_o  out  64  {remainder[63:32], quotient[31:0]}
- ready_o  out  1  `DivResultReady` when `result_o` is valid

## Operation
- Reset value of every output is 0; the state resets to `DivFree`.
- States are `DivFree`, `DivByZero`, `DivOn` and `DivEnd`.
- **DivFree**
  - If `start_i && !annul_i`:
    - divisor == 0 → `DivByZero`.
    - otherwise → `DivOn`. Latch |dividend| and |divisor|: two's-complement absolute value is taken only when `signed_div_i` and the operand MSB is 1. Also latch the original operand signs and `signed_div_i`, and clear the 6-bit iteration count.
  - Otherwise the FSM stays in `DivFree` and `result_o` is 0.
- **DivByZero**
  - Next state is `DivEnd` with result = 64'h0.
- **DivOn** (restoring algorithm, one quotient bit per cycle)
  - Working register is 65 bits: {partial remainder, dividend/quotient}.
  - Each cycle:
    - Form the 33-bit difference {0, rem[31:0]} − {0, divisor}.
    - Borrow → shift left, inserting quotient bit 0.
    - No borrow → replace rem with the difference, shift left, inserting quotient bit 1.
  - Count 0..31. After the step at count 31 → `DivEnd`.
  - Sign fixup happens on the transition into `DivEnd` (signed only):
    - The quotient is negated if the operand signs differ.
    - The remainder is negated if the dividend was negative.
  - `annul_i` = 1 → `DivFree` next cycle; the result is discarded and `ready_o` stays 0.
- **DivEnd**
  - `ready_o` = 1; `result_o` holds the final value.
  - If `start_i` = 0 → `DivFree`: `ready_o` goes to 0 and `result_o` to 0 on the next edge.
  - If `start_i` stays 1, the FSM remains in `DivEnd` (Ex stalled by a later stage).
- Arithmetic edge cases:
  - Signed −2^31 / −1 → quotient 32'h80000000, remainder 0. This falls out of the unsigned path; no special case is needed.
  - Unsigned operands are never negated.
- Operand inputs are ignored outside `DivFree`; Ex may change them freely.

## Timing
- Let start be sampled in `DivFree` at edge E0.
- Normal divide:
  - 32 `DivOn` cycles follow E0.
  - `ready_o` is high in the cycle after edge E0+33, i.e. 33 edges of latency.
- Divide by zero: `ready_o` is high after edge E0+2.
- `ready_o` is registered and stays high for as long as the FSM is in `DivEnd`.
- Start level again:
  - A new operation needs one `DivFree` cycle.
  - Back-to-back divides cost 1 extra cycle, because `start_i` must drop in `DivEnd`.
- Simultaneous `start_i` and `annul_i` in `DivFree`: annul wins and no operation begins.
- `annul_i` in `DivEnd`: return to `DivFree`.
- `rst` in any state overrides everything; state and outputs are 0 on the next edge.

## Structure
- Add to `Defines.v`:
  - state encodings `DivFree`/`DivByZero`/`DivOn`/`DivEnd` (2 bits)
  - `DivResultReady`/`DivResultNotReady`
  - `DivStart`/`DivStop`
  - `DoubleRegBus` (63:0)
- Single module, no sub-module; the iteration step is inline.
- Ex instantiation wires up the already-declared `div_opdata1_o`, `div_opdata2_o`, `signed_div_o`, `start_o`, `cancel_o` and `div_result_i`/`div_ready_i`.

## Test plan
- Unsigned 100 / 7, start held high:
  - `ready_o` rises 33 edges after start with result {32'd2, 32'd14}.
  - Drop start → `ready_o` and `result_o` are 0 one cycle later.
- Signed 0xFFFFFFF9 / 2 (−7 / 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Unsigned 0xFFFFFFFF / 0x10 → quotient 0x0FFFFFFF, remainder 0xF.
- Divide by zero (any dividend):
  - `ready_o` after 2 edges, result 64'h0.
  - Holding start for 5 extra cycles keeps ready and the result stable.
- Cancel and reset mid-operation:
  - Assert `annul_i` at iteration 10 → `DivFree` next edge, `ready_o` never rises. A following 9 / 3 returns {0, 3} at +33 edges.
  - Assert `rst` at iteration 20 → all outputs 0 next edge.
